// File: rtl/copro_sched_if.sv
// copro_sched_if: the bundle between the EXE stage, the coprocessor unit and
// copro_sched.
//   master : the pipeline/unit side. It drives start, cancel, operand, dest_in
//            and cop_result, and receives the sequencer outputs.
//   slave  : copro_sched itself.
// Signals:
//   start/cancel        EXE request and EXE flush
//   operand/dest_in     val1 and destination tag of the EXE instruction
//   cop_result          output of the fixed-latency unit
//   cop_go/cop_operand  start pulse and latched operand sent to the unit
//   freeze/busy         pipeline stall and BUSY indication
//   result_valid/result/result_dest  one-cycle result slot
//   op_count            completed operations, saturating
interface copro_sched_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic              cancel;
  logic [DATA_W-1:0] operand;
  logic [4:0]        dest_in;
  logic [DATA_W-1:0] cop_result;
  logic              cop_go;
  logic [DATA_W-1:0] cop_operand;
  logic              freeze;
  logic              busy;
  logic              result_valid;
  logic [DATA_W-1:0] result;
  logic [4:0]        result_dest;
  logic [15:0]       op_count;

  modport master (
    output start, cancel, operand, dest_in, cop_result,
    input  cop_go, cop_operand, freeze, busy, result_valid, result,
           result_dest, op_count
  );

  modport slave (
    input  start, cancel, operand, dest_in, cop_result,
    output cop_go, cop_operand, freeze, busy, result_valid, result,
           result_dest, op_count
  );
endinterface

// File: rtl/copro_sched.sv
// copro_sched: sequencer for the multi-cycle coprocessor unit in EXE.
// A request from the EXE instruction latches its operand and destination,
// fires one cop_go pulse to the fixed-latency unit, and freezes the pipeline
// until the unit's output is captured. The result is then presented for a
// single cycle (DONE) while the instruction advances to MEM.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-high reset
//   bus  copro_sched_if.slave (see the interface file for the signal list)
// Parameters:
//   LATENCY  cycles from cop_go sample to a valid cop_result (2..63)
//   DATA_W   operand/result width
module copro_sched #(
  parameter int LATENCY = 35,
  parameter int DATA_W  = 32
) (
  input  logic           clk,
  input  logic           rst,
  copro_sched_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // The down-counter is loaded with LATENCY-1 so that cnt==0 coincides with
  // the cycle in which the unit's output becomes valid.
  localparam logic [5:0] CNT_LOAD = 6'(LATENCY - 1);

  state_t            state;
  logic [5:0]        cnt;
  logic              cop_go_q;
  logic [DATA_W-1:0] cop_operand_q;
  logic [DATA_W-1:0] result_q;
  logic [4:0]        result_dest_q;
  logic [15:0]       op_count_q;

  // NOTE: all state lives in one clocked block using non-blocking
  // assignments, so every register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      cop_go_q      <= 1'b0;
      cop_operand_q <= '0;
      result_q      <= '0;
      result_dest_q <= '0;
      op_count_q    <= '0;
    end else begin
      // cop_go is a pulse: low unless the IDLE->BUSY edge raises it.
      cop_go_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start && !bus.cancel) begin
            state         <= BUSY;
            cop_operand_q <= bus.operand;
            result_dest_q <= bus.dest_in;
            cnt           <= CNT_LOAD;
            cop_go_q      <= 1'b1;
          end
        end
        BUSY: begin
          if (bus.cancel) begin
            // Flushed instruction: the in-flight unit output is discarded.
            state <= IDLE;
          end else if (cnt == 6'd0) begin
            state    <= DONE;
            result_q <= bus.cop_result;
            if (op_count_q != 16'hFFFF) begin
              op_count_q <= op_count_q + 16'd1;
            end
          end else begin
            cnt <= cnt - 6'd1;
          end
        end
        DONE: begin
          // start is still high from the instruction being released, so it
          // is deliberately not looked at here.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Combinational so the pipeline stalls in the request cycle itself. The
  // rst term keeps the stall off while reset is held with start high.
  assign bus.freeze       = ~rst & ~bus.cancel &
                            (((state == IDLE) & bus.start) | (state == BUSY));
  assign bus.busy         = (state == BUSY);
  assign bus.result_valid = (state == DONE) & ~bus.cancel;

  assign bus.cop_go       = cop_go_q;
  assign bus.cop_operand  = cop_operand_q;
  assign bus.result       = result_q;
  assign bus.result_dest  = result_dest_q;
  assign bus.op_count     = op_count_q;

endmodule

// File: tb/tb_copro_sched.sv
// Testbench for copro_sched. Two instances: dut (LATENCY=35) for timing,
// cancel and reset scenarios, and dut2 (LATENCY=2) for op_count saturation.
// Inputs are driven just after the falling edge and outputs sampled 1 time
// unit later, so each loop index is one clock cycle. Result values go through
// a scoreboard queue that is filled when a request is driven and drained when
// result_valid is seen.
module tb_copro_sched;

  localparam int          LAT  = 35;
  localparam int          LAT2 = 2;
  localparam logic [31:0] MASK = 32'hA5A5A5A5;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  copro_sched_if #(.DATA_W(32)) b  ();
  copro_sched_if #(.DATA_W(32)) b2 ();

  copro_sched #(.LATENCY(LAT),  .DATA_W(32)) dut  (.clk(clk), .rst(rst), .bus(b));
  copro_sched #(.LATENCY(LAT2), .DATA_W(32)) dut2 (.clk(clk), .rst(rst), .bus(b2));

  int          checks    = 0;
  int          failures  = 0;
  int          exp_count = 0;
  logic [31:0] last_result;
  logic [36:0] sb_q[$];

  // Unit model for dut: latches cop_operand on cop_go and shows operand^MASK
  // only in the cycle it is due (LATENCY-1 cycles after the cop_go cycle);
  // any other cycle shows a poison value so a mistimed capture is visible.
  int          m_age;
  logic [31:0] m_lat;

  always @(posedge clk) begin
    if (rst) begin
      m_age <= 0;
    end else if (b.cop_go) begin
      m_lat <= b.cop_operand;
      m_age <= 1;
    end else if (m_age != 0 && m_age < LAT) begin
      m_age <= m_age + 1;
    end
  end

  assign b.cop_result  = (m_age == LAT - 1) ? (m_lat ^ MASK) : 32'hDEADBEEF;
  assign b2.cop_result = b2.cop_operand ^ MASK;

  // Scoreboard drain for dut.
  always @(negedge clk) begin
    #2;
    if (b.result_valid === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_valid got result=%h dest=%0d required=no valid",
                 b.result, b.result_dest);
      end else begin
        logic [36:0] e;
        e = sb_q.pop_front();
        if ({b.result, b.result_dest} !== e) begin
          failures++;
          $display("FAIL sb_result got=%h/%0d required=%h/%0d",
                   b.result, b.result_dest, e[36:5], e[4:0]);
        end
      end
    end
  end

  // Expected {freeze, busy, cop_go, result_valid} for an uncancelled op
  // accepted rel cycles ago, with start held until its DONE cycle.
  function automatic logic [3:0] phase_vec(int rel, int lat);
    if (rel < 0 || rel > lat + 1) return 4'b0000;
    return {rel <= lat, (rel >= 1) && (rel <= lat), rel == 1, rel == lat + 1};
  endfunction

  task automatic test_reset();
    rst        = 1'b1;
    b.start    = 1'b1;
    b.cancel   = 1'b0;
    b.operand  = 32'h11111111;
    b.dest_in  = 5'd5;
    b2.start   = 1'b0;
    b2.cancel  = 1'b0;
    b2.operand = 32'h0000CAFE;
    b2.dest_in = 5'd1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({b.cop_go, b.freeze, b.busy, b.result_valid, b.result, b.result_dest,
           b.op_count, b.cop_operand} !== '0) begin
        failures++;
        $display("FAIL reset_outputs c=%0d got go=%b frz=%b busy=%b rv=%b res=%h dst=%0d cnt=%0d opd=%h required=all 0",
                 c, b.cop_go, b.freeze, b.busy, b.result_valid, b.result,
                 b.result_dest, b.op_count, b.cop_operand);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (b.freeze !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_freeze got=%b required=1", b.freeze);
    end
    // Withdraw the request before the edge so the op is not taken.
    b.start = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (b.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_idle got busy=%b required=0", b.busy);
    end
    exp_count   = 0;
    last_result = 32'h0;
  endtask

  task automatic test_single();
    logic [3:0] ev;
    for (int c = 0; c <= 38; c++) begin
      @(negedge clk);
      b.start   = (c <= 36);
      b.cancel  = 1'b0;
      b.operand = (c == 0) ? 32'h3F800000 : 32'hFFFFFFFF;
      b.dest_in = (c == 0) ? 5'd7 : 5'd31;
      if (c == 0) sb_q.push_back({32'h9A25A5A5, 5'd7});
      #1;
      ev = phase_vec(c, LAT);
      checks++;
      if ({b.freeze, b.busy, b.cop_go, b.result_valid} !== ev) begin
        failures++;
        $display("FAIL single_ctrl c=%0d got frz/busy/go/rv=%b required=%b",
                 c, {b.freeze, b.busy, b.cop_go, b.result_valid}, ev);
      end
      if (c == 1) begin
        checks++;
        if (b.cop_operand !== 32'h3F800000) begin
          failures++;
          $display("FAIL single_cop_operand got=%h required=3f800000", b.cop_operand);
        end
      end
    end
    exp_count++;
    last_result = 32'h9A25A5A5;
    checks++;
    if (b.op_count !== 16'(exp_count) || b.result !== last_result || b.result_dest !== 5'd7) begin
      failures++;
      $display("FAIL single_hold got cnt=%0d res=%h dst=%0d required cnt=%0d res=%h dst=7",
               b.op_count, b.result, b.result_dest, exp_count, last_result);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] op_a = 32'h12345678;
    logic [31:0] op_b = 32'hCAFEF00D;
    logic [3:0]  ev;
    for (int c = 0; c <= 75; c++) begin
      @(negedge clk);
      b.start   = (c <= 73);
      b.cancel  = 1'b0;
      b.operand = (c == 0) ? op_a : (c == 37) ? op_b : 32'h0BAD0BAD;
      b.dest_in = (c == 0) ? 5'd3 : (c == 37) ? 5'd12 : 5'd0;
      if (c == 0)  sb_q.push_back({op_a ^ MASK, 5'd3});
      if (c == 37) sb_q.push_back({op_b ^ MASK, 5'd12});
      #1;
      ev = (c < 37) ? phase_vec(c, LAT) : phase_vec(c - 37, LAT);
      checks++;
      if ({b.freeze, b.busy, b.cop_go, b.result_valid} !== ev) begin
        failures++;
        $display("FAIL b2b_ctrl c=%0d got frz/busy/go/rv=%b required=%b",
                 c, {b.freeze, b.busy, b.cop_go, b.result_valid}, ev);
      end
    end
    exp_count += 2;
    last_result = op_b ^ MASK;
    checks++;
    if (b.op_count !== 16'(exp_count)) begin
      failures++;
      $display("FAIL b2b_count got=%0d required=%0d", b.op_count, exp_count);
    end
  endtask

  task automatic test_cancel_mid();
    logic [3:0] ev;
    for (int c = 0; c <= 45; c++) begin
      @(negedge clk);
      b.start   = (c <= 10);
      b.cancel  = (c == 10);
      b.operand = 32'h0000FFFF;
      b.dest_in = 5'd9;
      #1;
      ev = (c < 10) ? phase_vec(c, LAT) : (c == 10) ? 4'b0100 : 4'b0000;
      checks++;
      if ({b.freeze, b.busy, b.cop_go, b.result_valid} !== ev) begin
        failures++;
        $display("FAIL cancel_mid_ctrl c=%0d got frz/busy/go/rv=%b required=%b",
                 c, {b.freeze, b.busy, b.cop_go, b.result_valid}, ev);
      end
    end
    b.cancel = 1'b0;
    checks++;
    if (b.op_count !== 16'(exp_count) || b.result !== last_result) begin
      failures++;
      $display("FAIL cancel_mid_state got cnt=%0d res=%h required cnt=%0d res=%h",
               b.op_count, b.result, exp_count, last_result);
    end
  endtask

  task automatic test_cancel_idle_done();
    logic [31:0] op_a = 32'h55AA00FF;
    logic [31:0] op_b = 32'h01020304;
    logic [3:0]  ev;
    // Cancel together with start in IDLE: no stall and no transition.
    @(negedge clk);
    b.start   = 1'b1;
    b.cancel  = 1'b1;
    b.operand = 32'h77777777;
    #1;
    checks++;
    if ({b.freeze, b.busy, b.cop_go, b.result_valid} !== 4'b0000) begin
      failures++;
      $display("FAIL cancel_idle_freeze got frz/busy/go/rv=%b required=0000",
               {b.freeze, b.busy, b.cop_go, b.result_valid});
    end
    @(negedge clk);
    b.start  = 1'b0;
    b.cancel = 1'b0;
    #1;
    checks++;
    if ({b.freeze, b.busy, b.cop_go, b.result_valid} !== 4'b0000) begin
      failures++;
      $display("FAIL cancel_idle_stay got frz/busy/go/rv=%b required=0000",
               {b.freeze, b.busy, b.cop_go, b.result_valid});
    end
    // Cancel in DONE: valid suppressed, next start taken the following cycle.
    for (int c = 0; c <= 76; c++) begin
      @(negedge clk);
      b.start   = (c <= 73);
      b.cancel  = (c == 36);
      b.operand = (c == 0) ? op_a : (c == 37) ? op_b : 32'h0BAD0BAD;
      b.dest_in = (c == 0) ? 5'd2 : (c == 37) ? 5'd30 : 5'd0;
      if (c == 37) sb_q.push_back({op_b ^ MASK, 5'd30});
      #1;
      ev = (c == 36) ? 4'b0000 : (c < 37) ? phase_vec(c, LAT) : phase_vec(c - 37, LAT);
      checks++;
      if ({b.freeze, b.busy, b.cop_go, b.result_valid} !== ev) begin
        failures++;
        $display("FAIL cancel_done_ctrl c=%0d got frz/busy/go/rv=%b required=%b",
                 c, {b.freeze, b.busy, b.cop_go, b.result_valid}, ev);
      end
      if (c == 37) begin
        checks++;
        if (b.result !== (op_a ^ MASK) || b.op_count !== 16'(exp_count + 1)) begin
          failures++;
          $display("FAIL cancel_done_capture got res=%h cnt=%0d required res=%h cnt=%0d",
                   b.result, b.op_count, op_a ^ MASK, exp_count + 1);
        end
      end
    end
    exp_count += 2;
    last_result = op_b ^ MASK;
    checks++;
    if (b.op_count !== 16'(exp_count)) begin
      failures++;
      $display("FAIL cancel_done_count got=%0d required=%0d", b.op_count, exp_count);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] ev;
    for (int c = 0; c <= 50; c++) begin
      @(negedge clk);
      rst       = (c == 20);
      b.start   = (c <= 20);
      b.cancel  = 1'b0;
      b.operand = 32'h76543210;
      b.dest_in = 5'd17;
      #1;
      ev = (c < 20) ? phase_vec(c, LAT) : (c == 20) ? 4'b0100 : 4'b0000;
      checks++;
      if ({b.freeze, b.busy, b.cop_go, b.result_valid} !== ev) begin
        failures++;
        $display("FAIL reset_mid_ctrl c=%0d got frz/busy/go/rv=%b required=%b",
                 c, {b.freeze, b.busy, b.cop_go, b.result_valid}, ev);
      end
    end
    exp_count   = 0;
    last_result = 32'h0;
    checks++;
    if (b.op_count !== 16'd0 || b.result !== 32'h0 || b.result_dest !== 5'd0) begin
      failures++;
      $display("FAIL reset_mid_state got cnt=%0d res=%h dst=%0d required all 0",
               b.op_count, b.result, b.result_dest);
    end
  endtask

  task automatic test_saturation();
    int done  = 0;
    int limit = 65537 * (LAT2 + 2) + 20;
    int cyc   = 0;
    int expc;
    @(negedge clk);
    b2.start = 1'b1;
    while (done < 65537 && cyc < limit) begin
      @(negedge clk);
      #1;
      cyc++;
      if (b2.result_valid) begin
        done++;
        if (done == 1000 || done >= 65534) begin
          expc = (done > 65535) ? 65535 : done;
          checks++;
          if (b2.op_count !== 16'(expc)) begin
            failures++;
            $display("FAIL sat_count ops=%0d got=%0d required=%0d", done, b2.op_count, expc);
          end
        end
      end
    end
    b2.start = 1'b0;
    checks++;
    if (done != 65537) begin
      failures++;
      $display("FAIL sat_timeout got ops=%0d required=65537", done);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_cancel_mid();
    test_cancel_idle_done();
    test_reset_mid();
    test_saturation();
    repeat (2) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover got=%0d required=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/copro_sched.md
# copro_sched

Sequencer for the multi-cycle coprocessor unit in the EXE stage. It accepts a coprocessor request from the instruction currently in EXE and latches its operand and destination. It issues a single start pulse to the fixed-latency unit, then holds the pipeline frozen until the result is captured. The result is presented for exactly one cycle, alongside the ALU result path, while the instruction advances to MEM.

## Interface
- LATENCY, 35: cycles from `cop_go` sample to a valid `cop_result`; legal range 2..63.
- DATA_W, 32: operand and result width.
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  EXE instruction is a coprocessor op; held high by the frozen pipeline until release.
- cancel  in  1  flush of the EXE instruction (taken branch/jump); aborts any operation.
- operand  in  DATA_W  source value (val1) of the EXE instruction.
- dest_in  in  5  destination register of the EXE instruction.
- cop_result  in  DATA_W  coprocessor unit output.
- cop_go  out  1  one-cycle start pulse to the unit.
- cop_operand  out  DATA_W  latched operand driven to the unit.
- freeze  out  1  stall PC, IF, ID and EXE registers.
- busy  out  1  state is BUSY.
- result_valid  out  1  result slot valid; EXE result mux selects `result`.
- result  out  DATA_W  captured coprocessor result.
- result_dest  out  5  destination tag latched with the request.
- op_count  out  16  completed (non-cancelled) operations, saturating at 16'hFFFF.

## Operation
- States: IDLE, BUSY, DONE. 6-bit down-counter `cnt`.
- IDLE:
  - `start & ~cancel` moves to BUSY at the next edge.
  - At the same edge: `cop_operand <= operand`, `result_dest <= dest_in`, `cnt <= LATENCY-1`, `cop_go <= 1`.
- BUSY:
  - `cop_go` is registered and high only in the first BUSY cycle.
  - `cnt` decrements each cycle.
  - When `cnt==0` and no cancel: at the next edge `result <= cop_result`, move to DONE, increment `op_count` (saturating).
- DONE: lasts exactly one cycle, then returns to IDLE unconditionally.
  - `start` is ignored here, because it is still asserted by the same instruction being released.
- `freeze = ~cancel & ((IDLE & start) | BUSY)`. It is combinational so the pipeline stalls in the request cycle itself.
- `result_valid = DONE & ~cancel`. `busy = BUSY`.
- `cancel` in BUSY: return to IDLE at the next edge; `result` and `op_count` are unchanged. The unit's in-flight output is discarded.
- `cancel` in IDLE: `start` is ignored for that cycle.
- `cancel` in DONE: no valid pulse; still goes to IDLE.
- Reset values: state IDLE, `cnt` 0, `cop_go` 0, `cop_operand` 0, `result` 0, `result_dest` 0, `op_count` 0. Therefore `freeze` 0, `busy` 0 and `result_valid` 0.
- Reset asserted mid-operation wins over every other input; the operation is lost.

## Timing
- Start high in IDLE in cycle 0:
  - `freeze` high in cycles 0..LATENCY, i.e. LATENCY+1 cycles.
  - `cop_go` high in cycle 1.
  - `cop_result` is sampled at the end of cycle LATENCY.
  - `result_valid` is high in cycle LATENCY+1 with `freeze` low.
- Earliest next accepted start is cycle LATENCY+2, giving back-to-back throughput of one op per LATENCY+2 cycles.
- `result` and `result_dest` hold their value until the next capture.

## Test plan
- **Reset:** hold `rst` 3 cycles with `start=1`. Required: all outputs 0; `freeze` 0 only while `rst` is held, then 1 in the first cycle after release.
- **Single op, LATENCY=35:** `start=1` in cycle 0 with `operand=32'h3F800000`, `dest_in=5'd7`, and the model unit returning `operand^32'hA5A5A5A5`. Required:
  - `cop_go` in cycle 1.
  - `freeze` high in cycles 0..35.
  - `result_valid` in cycle 36 with `result=32'h9A25A5A5` and `result_dest=7`.
  - `op_count=1`.
- **Back-to-back:** keep `start` high continuously. Required: DONE cycles at 36 and 73, second `cop_go` at cycle 38, `op_count=2`.
- **Cancel mid-op:** cancel in cycle 10. Required: `freeze=0` in cycle 10, IDLE in cycle 11, no `result_valid`, `op_count` unchanged, `result` unchanged.
- **Cancel with start in IDLE, and in DONE:**
  - Cancel with start in IDLE: no transition, `freeze=0`.
  - Cancel in DONE: `result_valid=0` in that cycle; a new start is accepted in the following cycle.
- **Reset mid-op and saturation:**
  - Assert `rst` in cycle 20. Required: IDLE next cycle, `cop_go` never re-pulses.
  - Preload via 65537 short ops with LATENCY=2. Required: `op_count` stays at 16'hFFFF.
